uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_pkg.sv | 14 +
 rtl/uart_rx.sv | 69 ++++++
 tb/tb_uart_rx.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: state encodings and frame timing constants shared by the UART receiver
package uart_rx_pkg;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DESFASO = 3'd1,
        ESPERO  = 3'd2,
        RECIBO  = 3'd3,
        FIN     = 3'd4
    } state_t;
    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int HALF_BIT   = OVERSAMPLE / 2;
    localparam int WAIT_TICKS = OVERSAMPLE - 1;
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled 8N1 receiver; clk/rst_n, rx serial in, d_out last byte, rx_done one-cycle strobe
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] d_out,
    output logic                 rx_done
);
    import uart_rx_pkg::*;
    localparam logic [3:0] half_end = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] wait_end = 4'(OVERSAMPLE - 2);
    localparam logic [3:0] n_fin    = 4'(DATA_BITS);
    localparam logic [3:0] n_stop   = 4'(DATA_BITS + 1);
    state_t               current_state, next_state;
    logic [3:0]           s, s_next, n, n_next;
    logic [DATA_BITS-1:0] buffer, buffer_next;
    always_comb begin
        next_state  = current_state;
        s_next      = s;
        n_next      = n;
        buffer_next = buffer;
        case (current_state)
            IDLE: begin
                s_next     = '0;
                n_next     = '0;
                next_state = rx ? IDLE : DESFASO;
            end
            DESFASO: begin
                s_next     = (s == half_end) ? 4'd0 : s + 4'd1;
                next_state = (s == half_end) ? ESPERO : DESFASO;
            end
            ESPERO: begin
                s_next     = (s == wait_end) ? 4'd0 : s + 4'd1;
                next_state = (s != wait_end) ? ESPERO : (n < n_fin) ? RECIBO : (n == n_fin) ? FIN : IDLE;
            end
            RECIBO: begin
                buffer_next = {rx, buffer[DATA_BITS-1:1]};
                n_next      = n + 4'd1;
                next_state  = ESPERO;
            end
            FIN: begin
                n_next     = n_stop;
                next_state = ESPERO;
            end
            default: next_state = IDLE;
        endcase
    end
    // d_out and rx_done are loaded on the edge that enters FIN so both are valid during FIN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            current_state <= IDLE;
            s             <= '0;
            n             <= '0;
            buffer        <= '0;
            d_out         <= '0;
            rx_done       <= 1'b0;
        end else begin
            current_state <= next_state;
            s             <= s_next;
            n             <= n_next;
            buffer        <= buffer_next;
            d_out         <= (next_state == FIN) ? buffer_next : d_out;
            rx_done       <= (next_state == FIN);
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scoreboard bench for uart_rx
module tb_uart_rx;
    import uart_rx_pkg::*;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] d_out;
    logic       rx_done;
    logic       prev_done = 1'b0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    uart_rx dut (.clk(clk), .rst_n(rst_n), .rx(rx), .d_out(d_out), .rx_done(rx_done));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rx_done === 1'b1) begin
            check("done_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("d_out_byte", 32'(d_out), 32'(exp_q.pop_front()));
            check("done_width", 32'(prev_done), 32'd0);
        end
        prev_done = rx_done;
    end

    task automatic send(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (16) @(negedge clk);
        end
        rx = stop;
        repeat (16) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (dut.current_state !== IDLE && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(tag, 32'(dut.current_state), 32'(IDLE));
    endtask

    task automatic chk_st(input string tag, input state_t st);
        check(tag, 32'(dut.current_state), 32'(st));
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_st("rst_state", IDLE);
        check("rst_s", 32'(dut.s), 32'd0);
        check("rst_n_cnt", 32'(dut.n), 32'd0);
        check("rst_buffer", 32'(dut.buffer), 32'd0);
        check("rst_d_out", 32'(d_out), 32'd0);
        check("rst_rx_done", 32'(rx_done), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            chk_st("idle_state", IDLE);
            check("idle_rx_done", 32'(rx_done), 32'd0);
        end
        check("idle_d_out", 32'(d_out), 32'd0);

        exp_q.push_back(8'hFF);
        @(negedge clk);
        rx = 1'b0;
        @(posedge clk);
        #1;
        chk_st("detect_desfaso", DESFASO);
        check("detect_s0", 32'(dut.s), 32'd0);
        repeat (7) @(posedge clk);
        #1;
        chk_st("desfaso_end", DESFASO);
        check("desfaso_s7", 32'(dut.s), 32'd7);
        @(negedge clk);
        rx = 1'b1;
        @(posedge clk);
        #1;
        chk_st("espero_start", ESPERO);
        check("espero_s0", 32'(dut.s), 32'd0);
        repeat (14) @(posedge clk);
        #1;
        chk_st("espero_end", ESPERO);
        check("espero_s14", 32'(dut.s), 32'd14);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            chk_st("recibo_state", RECIBO);
            check("recibo_n", 32'(dut.n), 32'(k));
            check("recibo_no_done", 32'(rx_done), 32'd0);
            @(posedge clk);
            #1;
            chk_st("after_recibo", ESPERO);
            check("after_recibo_n", 32'(dut.n), 32'(k + 1));
            repeat (14) @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        chk_st("fin_state", FIN);
        check("fin_rx_done", 32'(rx_done), 32'd1);
        check("fin_d_out", 32'(d_out), 32'hFF);
        @(posedge clk);
        #1;
        chk_st("guard_state", ESPERO);
        check("guard_rx_done", 32'(rx_done), 32'd0);
        check("guard_n9", 32'(dut.n), 32'd9);
        repeat (14) @(posedge clk);
        #1;
        chk_st("guard_not_idle", ESPERO);
        @(posedge clk);
        #1;
        chk_st("reenter_idle", IDLE);
        repeat (20) @(posedge clk);
        #1;
        chk_st("idle_hold", IDLE);
        check("ff_hold_d_out", 32'(d_out), 32'hFF);

        exp_q.push_back(8'hA5);
        send(8'hA5, 1'b1);
        wait_idle("a5_idle");
        exp_q.push_back(8'hA5);
        send(8'hA5, 1'b0);
        wait_idle("a5_bad_stop_idle");
        check("a5_bad_stop_d_out", 32'(d_out), 32'hA5);

        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        send(8'h3C, 1'b1);
        wait_idle("b2b_first_idle");
        check("b2b_first_d_out", 32'(d_out), 32'h3C);
        send(8'hC3, 1'b1);
        wait_idle("b2b_second_idle");
        check("b2b_second_d_out", 32'(d_out), 32'hC3);

        @(negedge clk);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (16) @(negedge clk);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (16) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_st("abort_state", IDLE);
        check("abort_s", 32'(dut.s), 32'd0);
        check("abort_n", 32'(dut.n), 32'd0);
        check("abort_buffer", 32'(dut.buffer), 32'd0);
        check("abort_d_out", 32'(d_out), 32'd0);
        check("abort_rx_done", 32'(rx_done), 32'd0);
        rx = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk_st("abort_wait_idle", IDLE);
        check("abort_hold_d_out", 32'(d_out), 32'd0);
        exp_q.push_back(8'h5A);
        send(8'h5A, 1'b1);
        wait_idle("post_abort_idle");
        check("post_abort_d_out", 32'(d_out), 32'h5A);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
